// File: rtl/lcd_mode_scheduler.sv
// Character LCD driver: power-up wait, init command sequence, then continuous
// two-line refresh from one of four character sources selected by mode.
module lcd_mode_scheduler #(
   parameter int unsigned CLK_DIV    = 50,
   parameter int unsigned POWER_WAIT = 750000,
   parameter int unsigned CLEAR_WAIT = 80000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_next,
   input  logic [7:0] char0,
   input  logic [7:0] char1,
   input  logic [7:0] char2,
   input  logic [7:0] char3,
   output logic [4:0] index,
   output logic [1:0] mode,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data,
   output logic       init_done
);

   localparam int unsigned MAX_WAIT = (POWER_WAIT > CLEAR_WAIT) ? POWER_WAIT : CLEAR_WAIT;
   localparam int unsigned CW       = $clog2(MAX_WAIT + CLK_DIV + 1);

   typedef enum logic [2:0] {PWR_WAIT, INIT_CMD, HOME, LINE_CHAR, LINE2_ADDR} state_t;
   typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_HIGH, PH_LOW} phase_t;

   state_t        state;
   phase_t        phase;
   logic [CW-1:0] cnt;
   logic [1:0]    cmd_idx;
   logic          pending;
   logic [7:0]    char_sel;

   assign lcd_rw = 1'b0;

   always_comb begin
      char_sel = char0;
      case (mode)
         2'd1:    char_sel = char1;
         2'd2:    char_sel = char2;
         2'd3:    char_sel = char3;
         default: char_sel = char0;
      endcase
   end

   function automatic logic [7:0] init_byte(input logic [1:0] i);
      case (i)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // phase sequences each bus write (setup, E high, E low); state decides
   // what to write next once a write's low phase completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= PWR_WAIT;
         phase     <= PH_IDLE;
         cnt       <= '0;
         cmd_idx   <= '0;
         index     <= '0;
         mode      <= '0;
         pending   <= 1'b0;
         init_done <= 1'b0;
         lcd_e     <= 1'b0;
         lcd_rs    <= 1'b0;
         lcd_data  <= '0;
      end else begin
         if (mode_next) pending <= 1'b1;
         unique case (phase)
            PH_SETUP: begin
               lcd_e <= 1'b1;
               phase <= PH_HIGH;
               cnt   <= '0;
            end
            PH_HIGH: begin
               if (cnt == CW'(CLK_DIV - 1)) begin
                  lcd_e <= 1'b0;
                  phase <= PH_LOW;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PH_LOW: begin
               if (cnt != CW'(CLK_DIV - 1)) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  cnt   <= '0;
                  phase <= PH_IDLE;
                  case (state)
                     INIT_CMD: begin
                        if (cmd_idx != 2'd3) begin
                           cmd_idx  <= cmd_idx + 2'd1;
                           lcd_data <= init_byte(cmd_idx + 2'd1);
                           phase    <= PH_SETUP;
                        end
                     end
                     HOME, LINE2_ADDR: state <= LINE_CHAR;
                     LINE_CHAR: begin
                        index <= index + 5'd1;
                        if (index == 5'd15) begin
                           state <= LINE2_ADDR;
                        end else if (index == 5'd31) begin
                           // frame boundary: the only place a mode change lands
                           state   <= HOME;
                           pending <= mode_next;
                           if (pending) mode <= mode + 2'd1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            PH_IDLE: begin
               case (state)
                  PWR_WAIT: begin
                     if (cnt == CW'(POWER_WAIT)) begin
                        state    <= INIT_CMD;
                        cmd_idx  <= '0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_byte(2'd0);
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  INIT_CMD: begin
                     if (cnt == CW'(CLEAR_WAIT - 1)) begin
                        init_done <= 1'b1;
                        state     <= HOME;
                        index     <= '0;
                        cnt       <= '0;
                        pending   <= mode_next;
                        if (pending) mode <= mode + 2'd1;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  HOME: begin
                     lcd_rs   <= 1'b0;
                     lcd_data <= 8'h80;
                     phase    <= PH_SETUP;
                  end
                  LINE2_ADDR: begin
                     lcd_rs   <= 1'b0;
                     lcd_data <= 8'hC0;
                     phase    <= PH_SETUP;
                  end
                  LINE_CHAR: begin
                     // two cycles after index settles the registered source is valid
                     if (cnt == CW'(1)) begin
                        lcd_rs   <= 1'b1;
                        lcd_data <= char_sel;
                        phase    <= PH_SETUP;
                        cnt      <= '0;
                     end else begin
                        cnt <= cnt + CW'(1);
                     end
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_mode_scheduler.sv
// Bench for lcd_mode_scheduler: bus-level decoder plus write-stream/mode model,
// directed mode/reset scenarios and randomized mode_next traffic.
module tb_lcd_mode_scheduler;

   localparam int unsigned CLK_DIV    = 4;
   localparam int unsigned POWER_WAIT = 20;
   localparam int unsigned CLEAR_WAIT = 10;
   localparam logic [7:0] INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
   localparam int REQ027_MODE [4] = '{1, 2, 3, 0};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mode_next = 1'b0;
   logic [7:0] char0 = '0, char1 = '0, char2 = '0, char3 = '0;
   logic [4:0] index;
   logic [1:0] mode;
   logic       lcd_rs, lcd_rw, lcd_e, init_done;
   logic [7:0] lcd_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lcd_mode_scheduler #(
      .CLK_DIV   (CLK_DIV),
      .POWER_WAIT(POWER_WAIT),
      .CLEAR_WAIT(CLEAR_WAIT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mode_next(mode_next),
      .char0    (char0),
      .char1    (char1),
      .char2    (char2),
      .char3    (char3),
      .index    (index),
      .mode     (mode),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_e    (lcd_e),
      .lcd_data (lcd_data),
      .init_done(init_done)
   );

   // mode blocks: registered character per index, distinct alphabet per mode
   always @(posedge clk) begin
      char0 <= 8'h41 + {3'b000, index};
      char1 <= 8'h61 + {3'b000, index};
      char2 <= 8'h30 + {3'b000, index};
      char3 <= 8'hA0 + {3'b000, index};
   end

   function automatic int src_char(input int m, input int i);
      case (m)
         0:       return ('h41 + i) % 256;
         1:       return ('h61 + i) % 256;
         2:       return ('h30 + i) % 256;
         default: return ('hA0 + i) % 256;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model state ----------------
   int         mm, cmd_i, frame_pos, clr_cnt, boot_cnt, hcnt, lcnt, ph;
   bit         mpend, clearing, home_edge, model_init, booted;
   logic [7:0] w_data, p_data;
   logic       w_rs, p_rs, p_e;
   logic [4:0] w_idx;
   logic [8:0] wlog [$];

   task automatic model_reset();
      mm = 0; mpend = 0; cmd_i = 0; frame_pos = 0; clearing = 0; clr_cnt = 0;
      home_edge = 0; model_init = 0; booted = 0; boot_cnt = 0;
      ph = 0; hcnt = 0; lcnt = 0; p_e = 0; p_data = '0; p_rs = 0;
      wlog.delete();
   endtask

   task automatic write_done();
      int exp_d, exp_rs, ci;
      wlog.push_back({w_rs, w_data});
      if (cmd_i < 4) begin
         chk("init_rs", w_rs, 0);
         chk("init_cmd", w_data, INIT_SEQ[cmd_i]);
         cmd_i++;
         if (cmd_i == 4) begin clearing = 1; clr_cnt = 0; end
      end else begin
         ci = -1;
         if (frame_pos == 0)       begin exp_d = 'h80; exp_rs = 0; end
         else if (frame_pos == 17) begin exp_d = 'hC0; exp_rs = 0; end
         else begin
            ci = (frame_pos < 17) ? frame_pos - 1 : frame_pos - 2;
            exp_d = src_char(mm, ci); exp_rs = 1;
         end
         chk("wr_rs", w_rs, exp_rs);
         chk("wr_data", w_data, exp_d);
         if (ci >= 0) chk("wr_index", w_idx, ci);
         frame_pos++;
         if (frame_pos == 34) begin frame_pos = 0; home_edge = 1; end
      end
   endtask

   task automatic monitor_step();
      bit entry;
      chk("lcd_rw", lcd_rw, 0);
      if (!booted) begin
         if (lcd_e) begin booted = 1; chk("pwr_wait_len", boot_cnt, POWER_WAIT + 1); end
         else boot_cnt++;
      end
      entry = home_edge;
      home_edge = 0;
      if (clearing) begin
         clr_cnt++;
         if (clr_cnt > CLEAR_WAIT) begin clearing = 0; entry = 1; model_init = 1; end
      end
      if (entry) begin
         if (mpend) mm = (mm + 1) % 4;
         mpend = mode_next;
         chk("home_index", index, 0);
      end else if (mode_next) begin
         mpend = 1;
      end
      chk("init_done", init_done, model_init);
      chk("mode", mode, mm);

      if (lcd_e && !p_e) begin
         if (ph == 2) chk("low_width", lcnt, CLK_DIV);
         chk("setup_data", lcd_data, p_data);
         chk("setup_rs", lcd_rs, p_rs);
         w_data = lcd_data; w_rs = lcd_rs; w_idx = index;
         ph = 1; hcnt = 1;
      end else if (lcd_e) begin
         hcnt++;
         chk("hold_data", lcd_data, w_data);
         chk("hold_rs", lcd_rs, w_rs);
         chk("hold_index", index, w_idx);
      end else if (p_e) begin
         chk("high_width", hcnt, CLK_DIV);
         chk("low_data", lcd_data, w_data);
         chk("low_rs", lcd_rs, w_rs);
         ph = 2; lcnt = 1;
      end else if (ph == 2) begin
         lcnt++;
         chk("low_data", lcd_data, w_data);
         chk("low_rs", lcd_rs, w_rs);
         if (lcnt == CLK_DIV) begin ph = 0; write_done(); end
      end
      p_e = lcd_e; p_data = lcd_data; p_rs = lcd_rs;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         #1;
         if (!rst) model_reset();
         else monitor_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse();
      @(negedge clk); mode_next = 1'b1;
      @(negedge clk); mode_next = 1'b0;
   endtask

   // kind 0: index==val; 1: index==val with lcd_e high; 2: init_done==val; 3: lcd_e==val
   task automatic wait_cond(input string name, input int kind, input int val, input int budget);
      int  n;
      bit  hit;
      n = 0;
      hit = 0;
      while (!hit && n < budget) begin
         @(negedge clk);
         n++;
         case (kind)
            0:       hit = (index == val);
            1:       hit = (index == val) && lcd_e;
            2:       hit = (init_done == val);
            default: hit = (lcd_e == val);
         endcase
      end
      if (!hit) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout_%s: waited %0d cycles without event", name, n);
      end
   endtask

   task automatic wait_home(input string name);
      wait_cond({name, "_i31"}, 0, 31, 1500);
      wait_cond({name, "_i0"}, 0, 0, 100);
   endtask

   task automatic chk_log(input string name, input int k, input int exp);
      if (k < wlog.size()) chk(name, wlog[k], exp);
      else chk({name, "_missing"}, wlog.size(), k + 1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // init sequence and first frame on mode 0
      wait_cond("first_e", 3, 1, 200);
      wait_home("frame1");
      wait_cond("frame2_i1", 0, 1, 200);
      chk_log("log_38", 0, 'h038);
      chk_log("log_01", 3, 'h001);
      chk_log("log_home", 4, 'h080);
      chk_log("log_A", 5, 'h141);
      chk_log("log_line2", 21, 'h0C0);
      chk_log("log_Q", 22, 'h151);
      chk_log("log_bq", 37, 'h160);
      chk_log("log_home2", 38, 'h080);
      chk_log("log_A2", 39, 'h141);

      // one pulse per frame, each applied at the following HOME
      for (int k = 0; k < 4; k++) begin
         wait_cond("seq_i10", 0, 10, 1500);
         pulse();
         wait_home("seq");
         chk("req027_mode", mode, REQ027_MODE[k]);
      end

      // three pulses mid-frame collapse into one step
      wait_cond("burst_i5", 0, 5, 1500);
      pulse(); pulse(); pulse();
      wait_home("burst");
      chk("burst_mode", mode, 1);
      wait_cond("burst_i1", 0, 1, 200);
      chk("burst_first_char", wlog[wlog.size() - 1], 'h161);

      // random mode_next traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         mode_next = ($urandom_range(0, 59) == 0);
      end
      @(negedge clk);
      mode_next = 1'b0;

      for (int t = 0; t < 3 && mode == 2'd0; t++) begin
         pulse();
         wait_home("nz");
      end

      // asynchronous reset in the middle of an E-high phase
      wait_cond("rst_i20", 1, 20, 1500);
      #2 rst = 1'b0;
      #1;
      chk("rst_lcd_e", lcd_e, 0);
      chk("rst_index", index, 0);
      chk("rst_mode", mode, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_init_done", init_done, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // pulses during power wait and init: one pending step at the first HOME
      repeat (5) @(negedge clk);
      pulse();
      wait_cond("re_first_e", 3, 1, 200);
      pulse();
      wait_cond("re_init", 2, 1, 400);
      wait_cond("re_i1", 0, 1, 200);
      chk("restart_mode", mode, 1);
      wait_home("final");
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_mode_scheduler.md
LCD_MODE_SCHEDULER -- requirements
Module: lcd_mode_scheduler

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  CLK_DIV, 50, clk cycles per lcd_e phase (high or low); minimum 4.
  POWER_WAIT, 750000, clk cycles idle after reset before the first command.
  CLEAR_WAIT, 80000, extra clk cycles after the 0x01 clear command.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  clk  in  1  system clock; the block's only clock.
  rst  in  1  reset, asynchronous, active-low.
  mode_next  in  1  debounced single-cycle pulse; advances the display mode.
  char0..char3  in  8 each  ASCII character from mode blocks 0..3 for the current index; each source registers it (1-cycle latency).
  index  out  5  character position requested from the mode blocks, 0..31.
  mode  out  2  active mode, selecting char0..char3.
  lcd_rs  out  1  0 = command, 1 = data.
  lcd_rw  out  1  constant 0.
  lcd_e  out  1  LCD enable strobe.
  lcd_data  out  8  LCD bus.
  init_done  out  1  high once the init sequence has completed.

Function
REQ-003 The FSM SHALL use the states PWR_WAIT, INIT_CMD, HOME, LINE_CHAR and LINE2_ADDR.
REQ-004 PWR_WAIT SHALL count POWER_WAIT cycles with lcd_e=0 and then enter INIT_CMD.
REQ-005 INIT_CMD SHALL issue the commands 0x38, 0x0C, 0x06 and 0x01 in that order with lcd_rs=0.
REQ-006 After 0x01 the block SHALL wait a further CLEAR_WAIT cycles, then set init_done=1 and enter HOME.
REQ-007 Every bus write SHALL follow this sequence: drive lcd_rs and lcd_data, then one setup cycle, then lcd_e=1 for CLK_DIV cycles, then lcd_e=0 for CLK_DIV cycles.
REQ-008 lcd_rs and lcd_data SHALL stay stable from the setup cycle through the end of the lcd_e low phase.
REQ-009 HOME SHALL write command 0x80, set index=0 and enter LINE_CHAR.
REQ-010 For each character, LINE_CHAR SHALL present index and wait 2 cycles.
REQ-011 LINE_CHAR SHALL then capture char[mode], write it as data (lcd_rs=1) and increment index.
REQ-012 After the write of index 15 the FSM SHALL go to LINE2_ADDR, which writes command 0xC0 and returns to LINE_CHAR with index=16.
REQ-013 After the write of index 31, index SHALL wrap to 0 and the FSM SHALL go to HOME, refreshing continuously.
REQ-014 A mode_next pulse SHALL set a pending flag at any time; multiple pulses before it is consumed SHALL count as one.
REQ-015 The pending flag SHALL be consumed only on entry to HOME: mode <= mode+1 modulo 4 (3 wraps to 0), and the flag clears.
REQ-016 The result SHALL be that no frame mixes characters from two modes.
REQ-017 A mode_next pulse arriving in the same cycle the flag is consumed SHALL set the flag again, so it is applied at the next HOME.
REQ-018 mode_next pulses received during PWR_WAIT or INIT_CMD SHALL be held pending and applied at the first HOME.
REQ-019 index SHALL change only between writes, never while lcd_e=1.

Reset
REQ-020 On rst=0, asynchronously: state=PWR_WAIT; all counters=0; index=0; mode=0; pending=0; init_done=0.
REQ-021 On rst=0, asynchronously: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00.
REQ-022 A reset asserted during an lcd_e high phase SHALL drop lcd_e immediately.
REQ-023 After release of reset, the full power-up and init sequence SHALL repeat.

Verification (CLK_DIV=4, POWER_WAIT=20, CLEAR_WAIT=10)
REQ-024 Release reset, model the bus -> 20 idle cycles, then 0x38, 0x0C, 0x06, 0x01 with rs=0; each lcd_e pulse is 4 cycles wide with 4 low cycles; init_done rises 10 cycles after the 0x01 write ends.
REQ-025 char0 = 0x41+index (registered) -> 0x80, then "A".."P" with rs=1, then 0xC0, then "Q".."`", then 0x80 again; 34 writes per frame.
REQ-026 Pulse mode_next three times during LINE_CHAR at index 5 -> the current frame stays on char0; the next frame uses char1 (mode=1, not 3).
REQ-027 Apply 4 separated pulses, each consumed at a HOME -> mode goes 1, 2, 3, 0.
REQ-028 Assert rst while lcd_e=1 at index 20 -> lcd_e, index and mode go to 0 in the same cycle; after release, a PWR_WAIT of 20 cycles precedes 0x38.
REQ-029 Check all writes -> lcd_data and lcd_rs never change while lcd_e=1; lcd_rw is always 0.
